// File: rtl/ram_scan_reader.sv
// ram_scan_reader: streams a frame of 16-bit words out of a synchronous RAM
// and serialises them MSB-first as 1-bit pixels, one per pix_en strobe.
// A small prefetch FIFO decouples the two-cycle RAM read loop from pixel
// consumption.
//
// Ports:
//   clk          rising-edge clock
//   reset        synchronous active-high reset
//   frame_start  one-cycle pulse, restarts the scan at base_addr
//   base_addr    word address of the first frame word
//   pix_en       pixel strobe, one pixel consumed per asserted cycle
//   ram_addr     word address to RAM, held outside ISSUE
//   ram_we       RAM write enable, always 0
//   ram_ub       RAM upper byte enable, always 1
//   ram_lb       RAM lower byte enable, always 1
//   ram_dout     RAM read data, valid one cycle after ram_addr
//   pixel        current pixel, 1 = black
//   pixel_valid  one-cycle strobe after each accepted pix_en
//   active       frame scan in progress
//   done         one-cycle pulse on frame completion
//   underrun     sticky: pixel requested with no data available
module ram_scan_reader #(
  parameter int unsigned FRAME_WORDS = 1024,
  parameter int unsigned FIFO_DEPTH  = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        frame_start,
  input  logic [9:0]  base_addr,
  input  logic        pix_en,
  output logic [9:0]  ram_addr,
  output logic        ram_we,
  output logic        ram_ub,
  output logic        ram_lb,
  input  logic [15:0] ram_dout,
  output logic        pixel,
  output logic        pixel_valid,
  output logic        active,
  output logic        done,
  output logic        underrun
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam logic [10:0]   FRAME_LEN = 11'(FRAME_WORDS);
  localparam logic [CW-1:0] DEPTH_C   = CW'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, ISSUE, CAPTURE} state_t;

  state_t        state, state_nxt;
  logic [9:0]    fetch_addr;
  logic [9:0]    addr_hold;
  logic [10:0]   words_left;
  logic          pending;
  logic [15:0]   fifo_mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] fifo_count;
  logic [15:0]   shreg;
  logic [4:0]    bit_cnt;

  logic fetch_ok, issue, capture, push, pop, take_pix, frame_end;

  assign ram_we = 1'b0;
  assign ram_ub = 1'b1;
  assign ram_lb = 1'b1;

  // Occupancy counts the in-flight read so the FIFO can never overflow.
  assign fetch_ok  = active && (words_left != '0) &&
                     ((fifo_count + CW'(pending)) < DEPTH_C);
  assign take_pix  = pix_en && active && !frame_start;
  assign push      = capture && !frame_start;
  assign pop       = take_pix && (bit_cnt == '0) && (fifo_count != '0);
  assign frame_end = active && (words_left == '0) && !pending &&
                     (fifo_count == '0) && (bit_cnt == '0);

  // State register
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    if (frame_start) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE:    if (fetch_ok) state_nxt = ISSUE;
        ISSUE:   state_nxt = CAPTURE;
        CAPTURE: state_nxt = fetch_ok ? ISSUE : IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  // FSM outputs
  always_comb begin
    issue    = (state == ISSUE);
    capture  = (state == CAPTURE);
    ram_addr = issue ? fetch_addr : addr_hold;
  end

  always_ff @(posedge clk) begin
    if (reset)      addr_hold <= '0;
    else if (issue) addr_hold <= fetch_addr;
  end

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= ram_dout;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_addr  <= '0;
      words_left  <= '0;
      pending     <= 1'b0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      fifo_count  <= '0;
      shreg       <= '0;
      bit_cnt     <= '0;
      pixel       <= 1'b0;
      pixel_valid <= 1'b0;
      active      <= 1'b0;
      done        <= 1'b0;
      underrun    <= 1'b0;
    end else if (frame_start) begin
      // Flushing the pointers and clearing pending drops any read in flight.
      fetch_addr  <= base_addr;
      words_left  <= FRAME_LEN;
      pending     <= 1'b0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      fifo_count  <= '0;
      shreg       <= '0;
      bit_cnt     <= '0;
      pixel_valid <= 1'b0;
      active      <= 1'b1;
      done        <= 1'b0;
      underrun    <= 1'b0;
    end else begin
      done        <= 1'b0;
      pixel_valid <= take_pix;

      if (issue) begin
        words_left <= words_left - 11'd1;
        fetch_addr <= fetch_addr + 10'd1;
        pending    <= 1'b1;
      end
      if (capture) pending <= 1'b0;

      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + CW'(1);
        2'b01:   fifo_count <= fifo_count - CW'(1);
        default: fifo_count <= fifo_count;
      endcase

      if (take_pix) begin
        if (bit_cnt != '0) begin
          pixel   <= shreg[15];
          shreg   <= {shreg[14:0], 1'b0};
          bit_cnt <= bit_cnt - 5'd1;
        end else if (fifo_count != '0) begin
          // Pop and emit the MSB in the same cycle; the rest waits in shreg.
          pixel   <= fifo_mem[rd_ptr][15];
          shreg   <= {fifo_mem[rd_ptr][14:0], 1'b0};
          bit_cnt <= 5'd15;
        end else begin
          pixel <= 1'b0;
          if ((words_left != '0) || pending) underrun <= 1'b1;
        end
      end

      if (frame_end) begin
        active <= 1'b0;
        done   <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_ram_scan_reader.sv
module tb_ram_scan_reader;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset;
  logic       frame_start;
  logic [9:0] base_addr;
  logic       pix_en;

  logic [15:0] mem [1024];

  logic [9:0]  ra2, ra3, ra8;
  logic        we2, we3, we8, ub2, ub3, ub8, lb2, lb3, lb8;
  logic [15:0] rd2, rd3, rd8;
  logic        px2, px3, px8, pv2, pv3, pv8, ac2, ac3, ac8;
  logic        dn2, dn3, dn8, ur2, ur3, ur8;

  always @(posedge clk) rd2 <= mem[ra2];
  always @(posedge clk) rd3 <= mem[ra3];
  always @(posedge clk) rd8 <= mem[ra8];

  ram_scan_reader #(.FRAME_WORDS(2), .FIFO_DEPTH(4)) u_d2 (
    .clk(clk), .reset(reset), .frame_start(frame_start), .base_addr(base_addr),
    .pix_en(pix_en), .ram_addr(ra2), .ram_we(we2), .ram_ub(ub2), .ram_lb(lb2),
    .ram_dout(rd2), .pixel(px2), .pixel_valid(pv2), .active(ac2), .done(dn2),
    .underrun(ur2));

  ram_scan_reader #(.FRAME_WORDS(3), .FIFO_DEPTH(4)) u_d3 (
    .clk(clk), .reset(reset), .frame_start(frame_start), .base_addr(base_addr),
    .pix_en(pix_en), .ram_addr(ra3), .ram_we(we3), .ram_ub(ub3), .ram_lb(lb3),
    .ram_dout(rd3), .pixel(px3), .pixel_valid(pv3), .active(ac3), .done(dn3),
    .underrun(ur3));

  ram_scan_reader #(.FRAME_WORDS(8), .FIFO_DEPTH(4)) u_d8 (
    .clk(clk), .reset(reset), .frame_start(frame_start), .base_addr(base_addr),
    .pix_en(pix_en), .ram_addr(ra8), .ram_we(we8), .ram_ub(ub8), .ram_lb(lb8),
    .ram_dout(rd8), .pixel(px8), .pixel_valid(pv8), .active(ac8), .done(dn8),
    .underrun(ur8));

  // Outputs of the instance currently under observation
  int         sel;
  logic [9:0] s_addr;
  logic       s_px, s_pv, s_ac, s_dn, s_ur;

  always_comb begin
    s_addr = ra2; s_px = px2; s_pv = pv2; s_ac = ac2; s_dn = dn2; s_ur = ur2;
    if (sel == 3) begin
      s_addr = ra3; s_px = px3; s_pv = pv3; s_ac = ac3; s_dn = dn3; s_ur = ur3;
    end else if (sel == 8) begin
      s_addr = ra8; s_px = px8; s_pv = pv8; s_ac = ac8; s_dn = dn8; s_ur = ur8;
    end
  end

  int   total = 0;
  int   bad = 0;
  int   done_cnt = 0;
  int   unexpected = 0;
  logic sb [$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // One clock; sample #1 after the edge, track done and drain the scoreboard.
  task automatic step();
    logic e;
    @(posedge clk);
    #1;
    if (s_dn === 1'b1) done_cnt++;
    if (s_pv === 1'b1) begin
      if (sb.size() == 0) begin
        unexpected++;
      end else begin
        e = sb.pop_front();
        chk("pixel", 32'(s_px), 32'(e));
      end
    end
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic start_frame(input logic [9:0] b);
    base_addr   = b;
    frame_start = 1'b1;
    step();
    frame_start = 1'b0;
  endtask

  task automatic push_word(input logic [15:0] w);
    for (int i = 15; i >= 0; i--) sb.push_back(w[i]);
  endtask

  task automatic pulse_pix(input int n);
    pix_en = 1'b1;
    run(n);
    pix_en = 1'b0;
  endtask

  logic [9:0] wrap_exp [7];
  logic [9:0] prev_addr;
  int         changes;

  initial begin
    reset = 1'b1; frame_start = 1'b0; pix_en = 1'b0; base_addr = '0; sel = 2;
    for (int i = 0; i < 1024; i++) mem[i] = 16'(i * 40503 + 4660);
    mem[10'h100] = 16'h8001;
    mem[10'h101] = 16'hFFFF;
    mem[10'h040] = 16'hA5C3;
    mem[10'h150] = 16'hDEAD;

    // Reset state
    run(3);
    reset = 1'b0;
    chk("rst_addr", 32'(s_addr), 32'h0);
    chk("rst_we", 32'(we2), 32'h0);
    chk("rst_ub", 32'(ub2), 32'h1);
    chk("rst_lb", 32'(lb2), 32'h1);
    chk("rst_pixel", 32'(s_px), 32'h0);
    chk("rst_pv", 32'(s_pv), 32'h0);
    chk("rst_active", 32'(s_ac), 32'h0);
    chk("rst_done", 32'(s_dn), 32'h0);
    chk("rst_underrun", 32'(s_ur), 32'h0);

    // Two-word frame, consumption after the FIFO has filled
    sel = 2; done_cnt = 0;
    start_frame(10'h100);
    run(8);
    chk("f2_active", 32'(s_ac), 32'h1);
    push_word(16'h8001);
    push_word(16'hFFFF);
    pulse_pix(32);
    run(4);
    chk("f2_done_cnt", 32'(done_cnt), 32'd1);
    chk("f2_active_end", 32'(s_ac), 32'h0);
    chk("f2_underrun", 32'(s_ur), 32'h0);
    chk("f2_sb_empty", 32'(sb.size()), 32'd0);

    // Address wrap 0x3FF -> 0x000, one issue every two cycles
    sel = 3;
    wrap_exp = '{10'h3FF, 10'h3FF, 10'h000, 10'h000, 10'h001, 10'h001, 10'h001};
    start_frame(10'h3FF);
    for (int i = 0; i < 7; i++) begin
      step();
      chk("wrap_addr", 32'(s_addr), 32'(wrap_exp[i]));
    end

    // Continuous pix_en from the cycle after frame_start: three starved
    // pixels while the first word is fetched, then every data bit
    sel = 8; done_cnt = 0;
    start_frame(10'h040);
    for (int i = 0; i < 3; i++) sb.push_back(1'b0);
    for (int i = 0; i < 8; i++) push_word(mem[10'h040 + 10'(i)]);
    pulse_pix(3 + 16 * 8);
    run(4);
    chk("cont_underrun", 32'(s_ur), 32'h1);
    chk("cont_done_cnt", 32'(done_cnt), 32'd1);
    chk("cont_active_end", 32'(s_ac), 32'h0);
    chk("cont_sb_empty", 32'(sb.size()), 32'd0);

    // frame_start during CAPTURE discards the in-flight word
    done_cnt = 0;
    start_frame(10'h150);
    step();
    chk("abort_issue_addr", 32'(s_addr), 32'h150);
    step();
    base_addr   = 10'h200;
    frame_start = 1'b1;
    step();
    frame_start = 1'b0;
    chk("abort_addr_hold", 32'(s_addr), 32'h150);
    chk("abort_underrun_clr", 32'(s_ur), 32'h0);
    sb.push_back(1'b0);
    pix_en = 1'b1;
    step();
    pix_en = 1'b0;
    chk("abort_reissue_addr", 32'(s_addr), 32'h200);
    chk("abort_fifo_empty", 32'(s_ur), 32'h1);
    run(20);
    for (int i = 0; i < 8; i++) push_word(mem[10'h200 + 10'(i)]);
    pulse_pix(128);
    run(4);
    chk("abort_done_cnt", 32'(done_cnt), 32'd1);
    chk("abort_underrun_sticky", 32'(s_ur), 32'h1);
    chk("abort_sb_empty", 32'(sb.size()), 32'd0);

    // No consumption: prefetch stops after FIFO_DEPTH reads
    done_cnt = 0;
    start_frame(10'h300);
    prev_addr = s_addr;
    changes = 0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (s_addr !== prev_addr) changes++;
      prev_addr = s_addr;
    end
    chk("idle_reads", 32'(changes), 32'd4);
    chk("idle_last_addr", 32'(s_addr), 32'h303);
    chk("idle_active", 32'(s_ac), 32'h1);
    chk("idle_underrun", 32'(s_ur), 32'h0);
    for (int i = 0; i < 8; i++) push_word(mem[10'h300 + 10'(i)]);
    pulse_pix(128);
    run(4);
    chk("idle_done_cnt", 32'(done_cnt), 32'd1);
    chk("idle_underrun_end", 32'(s_ur), 32'h0);
    chk("idle_sb_empty", 32'(sb.size()), 32'd0);

    // Reset mid-frame with frame_start and pix_en in the same cycle
    done_cnt = 0;
    start_frame(10'h100);
    sb.push_back(1'b0); sb.push_back(1'b0); sb.push_back(1'b0); sb.push_back(1'b1);
    pulse_pix(4);
    chk("mid_underrun", 32'(s_ur), 32'h1);
    chk("mid_pixel", 32'(s_px), 32'h1);
    reset = 1'b1; frame_start = 1'b1; pix_en = 1'b1; base_addr = 10'h3AA;
    step();
    reset = 1'b0; frame_start = 1'b0; pix_en = 1'b0;
    chk("mrst_addr", 32'(s_addr), 32'h0);
    chk("mrst_pixel", 32'(s_px), 32'h0);
    chk("mrst_pv", 32'(s_pv), 32'h0);
    chk("mrst_active", 32'(s_ac), 32'h0);
    chk("mrst_done", 32'(s_dn), 32'h0);
    chk("mrst_underrun", 32'(s_ur), 32'h0);
    chk("mrst_active_d2", 32'(ac2), 32'h0);
    chk("mrst_active_d3", 32'(ac3), 32'h0);
    run(30);
    chk("mrst_active_late", 32'(s_ac), 32'h0);
    chk("mrst_addr_late", 32'(s_addr), 32'h0);
    chk("mrst_no_done", 32'(done_cnt), 32'd0);
    chk("mrst_sb_empty", 32'(sb.size()), 32'd0);
    chk("unexpected_pixels", 32'(unexpected), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ram_scan_reader.md
RAM_SCAN_READER -- requirements
Module: ram_scan_reader

Interface
REQ-001 Parameter: FRAME_WORDS, default 1024, number of 16-bit words read per frame (1..1024).
REQ-002 Parameter: FIFO_DEPTH, default 4, prefetch FIFO depth in words (power of two, >=2).
REQ-003 clk  input  1  single clock; all logic on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 frame_start  input  1  one-cycle pulse; restarts scan at base_addr.
REQ-006 base_addr  input  10  word address [10:1] of first frame word; sampled on frame_start.
REQ-007 pix_en  input  1  pixel strobe; one pixel consumed per asserted cycle.
REQ-008 ram_addr  output  10  word address [10:1] to RAM.
REQ-009 ram_we  output  1  RAM write enable; constant 0.
REQ-010 ram_ub, ram_lb  output  1 each  byte enables; constant 1.
REQ-011 ram_dout  input  16  RAM read data; valid exactly one cycle after ram_addr is presented.
REQ-012 pixel  output  1  current pixel, 1 = black.
REQ-013 pixel_valid  output  1  high for one cycle after each consumed pix_en.
REQ-014 active  output  1  high while a frame scan is in progress.
REQ-015 done  output  1  one-cycle pulse when a frame completes.
REQ-016 underrun  output  1  sticky; set when a pixel is requested with no data available.

Function
REQ-017 The fetch FSM SHALL have states IDLE, ISSUE and CAPTURE.
REQ-018 IDLE->ISSUE: active, words_left>0, fifo_count+pending < FIFO_DEPTH.
REQ-019 ISSUE SHALL drive ram_addr=fetch_addr for one cycle, decrement words_left, increment fetch_addr modulo 1024 (1023 wraps to 0), set pending, then go to CAPTURE.
REQ-020 CAPTURE SHALL write ram_dout into the FIFO, clear pending, and go to ISSUE if the REQ-018 condition still holds, else IDLE (back-to-back reads, one word per two cycles).
REQ-021 frame_start SHALL load fetch_addr=base_addr and words_left=FRAME_WORDS, flush the FIFO and shifter, clear pending, set active and go to IDLE; an in-flight read SHALL be discarded, not written to the FIFO.
REQ-022 The shifter SHALL hold one word and a 5-bit bit count (0 = empty).
REQ-023 On pix_en with active and bit count>0: pixel<=shreg[15], shift left, count-1.
REQ-024 On pix_en with bit count=0 and FIFO non-empty: pop a word, pixel<=word[15], load word<<1, count=15, in the same cycle.
REQ-025 On pix_en with bit count=0 and FIFO empty while words_left>0 or pending: pixel<=0, set underrun; no word is skipped.
REQ-026 A FIFO push and pop in the same cycle SHALL leave fifo_count unchanged.
REQ-027 pixel_valid SHALL assert the cycle after every pix_en accepted while active; pix_en while inactive SHALL be ignored.
REQ-028 When words_left=0, pending=0, FIFO empty and bit count=0, active SHALL clear and done SHALL pulse for one cycle.
REQ-029 frame_start SHALL take priority over pix_en and over fetch in the same cycle.
REQ-030 underrun SHALL clear only on reset or frame_start.
REQ-031 ram_addr SHALL hold its last value outside ISSUE.

Reset
REQ-032 reset SHALL force: FSM=IDLE, active=0, done=0, pixel=0, pixel_valid=0, underrun=0, ram_addr=0, FIFO empty, bit count=0, pending=0, words_left=0.
REQ-033 reset SHALL override frame_start and pix_en in the same cycle; reset mid-frame aborts the scan with no done pulse.

Verification
REQ-034 RAM model words 0x0100=0x8001, 0x0101=0xFFFF; FRAME_WORDS=2; frame_start, base_addr=0x100; pix_en held high after FIFO fill -> pixels 1,0x14,1 then 16x1, done pulse, underrun=0.
REQ-035 base_addr=0x3FF, FRAME_WORDS=3 -> ram_addr sequence 0x3FF,0x000,0x001, one ISSUE every two cycles.
REQ-036 pix_en continuous from the cycle after frame_start -> underrun=1, first pixel=0, no word lost; total 16*FRAME_WORDS data pixels delivered.
REQ-037 frame_start asserted in a CAPTURE cycle with base_addr=0x200 -> captured word discarded, next ISSUE at 0x200, FIFO empty.
REQ-038 pix_en never asserted, FRAME_WORDS=8 -> exactly FIFO_DEPTH reads issued, then FSM stays IDLE.
REQ-039 reset asserted mid-frame with frame_start same cycle -> all outputs at REQ-032 values, active=0, no done.
